// File: rtl/ble_rx_pkg.sv
// Shared types, constants and LFSR step helpers for the BLE LE 1M receive engine.
// BLE_RX_PREAMBLE_CHECK_EN widens the search window to include the preamble byte.
package ble_rx_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    HEADER,
    PAYLOAD,
    CRC,
    HOLD
  } rx_state_e;

  localparam logic [23:0] CRC_POLY     = 24'h00065B;
  localparam int          AA_LEN       = 32;
  localparam int          PREAMBLE_LEN = 8;
  localparam int          HDR_BITS     = 16;
  localparam int          CRC_BITS     = 24;
  localparam int          LEN_FIELD_W  = 6;

`ifdef BLE_RX_PREAMBLE_CHECK_EN
  localparam int SEARCH_W = AA_LEN + PREAMBLE_LEN;
`else
  localparam int SEARCH_W = AA_LEN;
`endif

  // 7-bit whitening LFSR: shift right, old bit0 re-enters at bit6 and taps bit2.
  function automatic logic [6:0] whiten_step(input logic [6:0] l);
    return {l[0], l[6:4], l[3] ^ l[0], l[2:1]};
  endfunction

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

endpackage

// File: rtl/ble_dewhiten_crc.sv
// Dewhitening LFSR and CRC24 register; both load together on an access-address hit
// and step once per received bit. o_crc_zero reflects the CRC after the current bit.
module ble_dewhiten_crc
  import ble_rx_pkg::*;
#(
  parameter logic [23:0] CRC_INIT = 24'h555555
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [5:0] i_channel,
  input  logic       i_bit,
  output logic       o_dw_bit,
  output logic       o_crc_zero
);

  logic [6:0]  r_lfsr;
  logic [23:0] r_crc;
  logic        w_dw;
  logic [23:0] w_crc_nxt;

  assign w_dw       = i_bit ^ r_lfsr[0];
  assign w_crc_nxt  = crc_step(r_crc, w_dw);
  assign o_dw_bit   = w_dw;
  assign o_crc_zero = (w_crc_nxt == 24'h000000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 7'h40;
      r_crc  <= CRC_INIT;
    end else if (i_load) begin
      r_lfsr <= {1'b1, i_channel};
      r_crc  <= CRC_INIT;
    end else if (i_step) begin
      r_lfsr <= whiten_step(r_lfsr);
      r_crc  <= w_crc_nxt;
    end
  end

endmodule

// File: rtl/ble_ll_rx_engine.sv
// BLE LE 1M link-layer receiver: multi-slot access-address search, dewhitening, length
// parse, CRC24 check and valid/ready packet hand-off. Option: BLE_RX_PREAMBLE_CHECK_EN.
module ble_ll_rx_engine
  import ble_rx_pkg::*;
#(
  parameter int          NUM_ADDR      = 4,
  parameter int          MAX_PDU_BYTES = 39,
  parameter logic [23:0] CRC_INIT      = 24'h555555,
  parameter int          CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       symbol_valid,
  input  logic                       symbol_in,
  input  logic [5:0]                 channel,
  input  logic [32*NUM_ADDR-1:0]     acc_addr,
  input  logic [NUM_ADDR-1:0]        addr_slot_en,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [8*MAX_PDU_BYTES-1:0] pkt_data,
  output logic [5:0]                 pkt_len,
  output logic [2:0]                 pkt_slot,
  output logic                       pkt_crc_ok,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           crc_err_count,
  output logic [CNT_W-1:0]           overflow_count
);

  localparam int                     IDX_W   = $clog2(8 * MAX_PDU_BYTES);
  localparam logic [LEN_FIELD_W-1:0] MAX_LEN = LEN_FIELD_W'(MAX_PDU_BYTES - 2);

  rx_state_e               r_state, w_state_nxt;
  logic [SEARCH_W-2:0]     r_sr;
  logic [SEARCH_W-1:0]     w_sr_nxt;
  logic [IDX_W-1:0]        r_cnt;
  logic                    w_hit, w_slot_hit;
  logic [2:0]              w_hit_slot;
  logic                    w_sym, w_load, w_step, w_accept;
  logic                    w_dw_bit, w_crc_zero;
  logic [LEN_FIELD_W-1:0]  w_hdr_len;
  logic                    w_ovf, w_hdr_last, w_pay_last, w_crc_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_sym      = en && symbol_valid;
  assign w_hdr_len  = pkt_data[8 +: LEN_FIELD_W];
  assign w_ovf      = (w_hdr_len > MAX_LEN);
  assign w_hdr_last = (r_cnt == IDX_W'(HDR_BITS - 1));
  assign w_pay_last = (r_cnt == IDX_W'(HDR_BITS - 1 + 8 * int'(pkt_len)));
  assign w_crc_last = (r_cnt == IDX_W'(CRC_BITS - 1));

  // The oldest symbol falls off the end, so only SEARCH_W-1 bits need storage.
  always_comb begin
    w_sr_nxt   = {symbol_in, r_sr};
    w_hit      = 1'b0;
    w_hit_slot = '0;
    w_slot_hit = 1'b0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      w_slot_hit = addr_slot_en[i] &&
                   (w_sr_nxt[SEARCH_W-1 -: AA_LEN] == acc_addr[AA_LEN*i +: AA_LEN]);
`ifdef BLE_RX_PREAMBLE_CHECK_EN
      w_slot_hit = w_slot_hit &&
                   (w_sr_nxt[PREAMBLE_LEN-1:0] == (acc_addr[AA_LEN*i] ? 8'h55 : 8'hAA));
`endif
      if (w_slot_hit) begin
        w_hit      = 1'b1;
        w_hit_slot = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEARCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SEARCH:  if (w_sym && w_hit) w_state_nxt = HEADER;
      HEADER: begin
        if (!en) w_state_nxt = SEARCH;
        else if (symbol_valid && w_hdr_last)
          w_state_nxt = w_ovf ? SEARCH : ((w_hdr_len == '0) ? CRC : PAYLOAD);
      end
      PAYLOAD: begin
        if (!en) w_state_nxt = SEARCH;
        else if (symbol_valid && w_pay_last) w_state_nxt = CRC;
      end
      CRC: begin
        if (!en) w_state_nxt = SEARCH;
        else if (symbol_valid && w_crc_last) w_state_nxt = HOLD;
      end
      HOLD:    if (pkt_ready) w_state_nxt = SEARCH;
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_accept  = 1'b0;
    pkt_valid = 1'b0;
    unique case (r_state)
      SEARCH:               w_load = w_sym && w_hit;
      HEADER, PAYLOAD, CRC: w_step = w_sym;
      HOLD: begin
        pkt_valid = 1'b1;
        w_accept  = pkt_ready;
      end
      default: ;
    endcase
  end

  ble_dewhiten_crc #(
    .CRC_INIT(CRC_INIT)
  ) u_dewhiten_crc (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_channel (channel),
    .i_bit     (symbol_in),
    .o_dw_bit  (w_dw_bit),
    .o_crc_zero(w_crc_zero)
  );

  // r_cnt indexes pkt_data through header and payload, then restarts to count CRC bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr           <= '0;
      r_cnt          <= '0;
      pkt_data       <= '0;
      pkt_len        <= '0;
      pkt_slot       <= '0;
      pkt_crc_ok     <= 1'b0;
      pkt_count      <= '0;
      crc_err_count  <= '0;
      overflow_count <= '0;
    end else begin
      if (r_state == SEARCH && w_sym) r_sr <= w_load ? '0 : w_sr_nxt[SEARCH_W-1:1];
      if (w_load) begin
        pkt_slot <= w_hit_slot;
        pkt_data <= '0;
        r_cnt    <= '0;
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state != CRC) pkt_data[r_cnt] <= w_dw_bit;
        if (r_state == HEADER && w_hdr_last) begin
          if (w_ovf) overflow_count <= sat_inc(overflow_count);
          else       pkt_len        <= w_hdr_len;
          if (w_hdr_len == '0) r_cnt <= '0;
        end
        if (r_state == PAYLOAD && w_pay_last) r_cnt <= '0;
        if (r_state == CRC && w_crc_last) pkt_crc_ok <= w_crc_zero;
      end
      if (w_accept) begin
        pkt_count <= sat_inc(pkt_count);
        if (!pkt_crc_ok) crc_err_count <= sat_inc(crc_err_count);
      end
    end
  end

endmodule

// File: tb/tb_ble_ll_rx_engine.sv
// Directed + randomized bench for ble_ll_rx_engine with an over-the-air packet model.
// Optional build macro BLE_RX_PREAMBLE_CHECK_EN changes the preamble expectations.
module tb_ble_ll_rx_engine;

  localparam int          NA     = 4;
  localparam int          MPB    = 39;
  localparam int          CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;
  localparam logic [31:0] ADV_AA = 32'h8E89BED6;

  logic              clk = 1'b0;
  logic              rst, en, symbol_valid, symbol_in, pkt_ready;
  logic [5:0]        channel;
  logic [32*NA-1:0]  acc_addr;
  logic [NA-1:0]     addr_slot_en;
  logic              pkt_valid;
  logic [8*MPB-1:0]  pkt_data;
  logic [5:0]        pkt_len;
  logic [2:0]        pkt_slot;
  logic              pkt_crc_ok;
  logic [CW-1:0]     pkt_count, crc_err_count, overflow_count;

  int checks = 0, failures = 0;
  int exp_pkt = 0, exp_err = 0, exp_ovf = 0;
  logic [7:0]       pdu [0:63];
  logic [8*MPB-1:0] exp_data;
  bit               mon_on = 1'b0;
  int               mon_cycles = 0, mon_bad = 0;

  always #5 clk = ~clk;

  ble_ll_rx_engine #(
    .NUM_ADDR(NA), .MAX_PDU_BYTES(MPB), .CRC_INIT(24'h555555), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .symbol_valid(symbol_valid), .symbol_in(symbol_in),
    .channel(channel), .acc_addr(acc_addr), .addr_slot_en(addr_slot_en),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_len(pkt_len),
    .pkt_slot(pkt_slot), .pkt_crc_ok(pkt_crc_ok), .pkt_count(pkt_count),
    .crc_err_count(crc_err_count), .overflow_count(overflow_count)
  );

  always @(negedge clk) begin
    if (mon_on) begin
      mon_cycles++;
      if (pkt_data !== exp_data || pkt_valid !== 1'b1) mon_bad++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [8*MPB-1:0] obs, input logic [8*MPB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic logic [6:0] wh_next(input logic [6:0] l);
    logic [6:0] n;
    n    = {l[0], l[6:1]};
    n[2] = n[2] ^ l[0];
    return n;
  endfunction

  function automatic logic [23:0] crc_next(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    symbol_in    = b;
    symbol_valid = 1'b1;
    tick();
    symbol_valid = 1'b0;
    symbol_in    = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic fill_pdu(input int len);
    pdu[0] = 8'($urandom);
    pdu[1] = {2'($urandom), 6'(len)};
    for (int i = 2; i < 64; i++) pdu[i] = 8'($urandom);
  endtask

  // Over-the-air stream: preamble, AA, whitened PDU, whitened CRC (MSB first).
  task automatic send_pkt(input logic [5:0] ch, input int nbytes, input int flip,
                          input bit bad_pre, input int nbits);
    bit          q[$];
    logic [6:0]  lf;
    logic [23:0] c;
    logic [7:0]  pre;
    logic [31:0] aa;
    logic        b;
    aa = ADV_AA;
    lf = {1'b1, ch};
    c  = 24'h555555;
    pre = aa[0] ? 8'h55 : 8'hAA;
    if (bad_pre) pre = ~pre;
    for (int i = 0; i < 8; i++)  q.push_back(pre[i]);
    for (int i = 0; i < 32; i++) q.push_back(aa[i]);
    for (int i = 0; i < 8 * nbytes; i++) begin
      b = pdu[i / 8][i % 8];
      c = crc_next(c, b);
      q.push_back(b ^ lf[0]);
      lf = wh_next(lf);
    end
    for (int i = 23; i >= 0; i--) begin
      q.push_back(c[i] ^ lf[0]);
      lf = wh_next(lf);
    end
    if (flip >= 0) q[40 + flip] = ~q[40 + flip];
    channel = ch;
    for (int i = 0; i < q.size() && (nbits < 0 || i < nbits); i++)
      send_bit(q[i], $urandom_range(0, 1));
  endtask

  task automatic set_exp(input int nbytes, input int flip);
    exp_data = '0;
    for (int i = 0; i < nbytes; i++) exp_data[8*i +: 8] = pdu[i];
    if (flip >= 0) exp_data[flip] = ~exp_data[flip];
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8 && pkt_valid !== 1'b1; i++) tick();
  endtask

  task automatic accept(input bit ok);
    pkt_ready    = 1'b1;
    symbol_valid = 1'b1;
    symbol_in    = 1'($urandom);
    tick();
    pkt_ready    = 1'b0;
    symbol_valid = 1'b0;
    exp_pkt = sat(exp_pkt + 1);
    if (!ok) exp_err = sat(exp_err + 1);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_count"}, pkt_count, exp_pkt);
    chk({tag, "_crc_err_count"}, crc_err_count, exp_err);
    chk({tag, "_overflow_count"}, overflow_count, exp_ovf);
  endtask

  task automatic rx_check(input string tag, input int len, input int slot, input bit ok);
    wait_valid();
    chk({tag, "_valid"}, pkt_valid, 1'b1);
    chk({tag, "_len"}, pkt_len, len);
    chk({tag, "_slot"}, pkt_slot, slot);
    chk({tag, "_crc_ok"}, pkt_crc_ok, ok);
    chk({tag, "_data"}, pkt_data, exp_data);
    if (pkt_valid === 1'b1) accept(ok);
    chk({tag, "_valid_drop"}, pkt_valid, 1'b0);
    chk_counters(tag);
  endtask

  initial begin
    int len, flip, fs, es;
    logic [5:0] ch;
    rst = 1'b1; en = 1'b0; symbol_valid = 1'b0; symbol_in = 1'b0; pkt_ready = 1'b0;
    channel = '0; acc_addr = '0; addr_slot_en = '0; exp_data = '0;
    repeat (3) tick();
    chk("rst_valid", pkt_valid, 1'b0);
    chk("rst_data", pkt_data, '0);
    chk("rst_len", pkt_len, '0);
    chk("rst_slot", pkt_slot, '0);
    chk("rst_crc_ok", pkt_crc_ok, 1'b0);
    chk_counters("rst");
    rst = 1'b0;
    en  = 1'b1;
    for (int s = 0; s < NA; s++) acc_addr[32*s +: 32] = $urandom;
    acc_addr[31:0] = ADV_AA;
    addr_slot_en   = 4'b0001;
    tick();

    fill_pdu(6);
    send_pkt(6'd37, 8, -1, 1'b0, -1);
    set_exp(8, -1);
    rx_check("adv", 6, 0, 1'b1);

    flip = 16 + $urandom_range(0, 47);
    send_pkt(6'd37, 8, flip, 1'b0, -1);
    set_exp(8, flip);
    rx_check("flip", 6, 0, 1'b0);

    acc_addr[32*2 +: 32] = ADV_AA;
    acc_addr[32*3 +: 32] = ADV_AA;
    addr_slot_en = 4'b1110;
    fill_pdu(10);
    send_pkt(6'd12, 12, -1, 1'b0, -1);
    set_exp(12, -1);
    rx_check("slot2", 10, 2, 1'b1);

    fill_pdu(38);
    send_pkt(6'd5, 40, -1, 1'b0, 40 + 16);
    repeat (8) send_bit(1'($urandom), 0);
    exp_ovf = sat(exp_ovf + 1);
    chk("ovf_no_valid", pkt_valid, 1'b0);
    chk_counters("ovf");

    fill_pdu(37);
    send_pkt(6'd20, 39, -1, 1'b0, -1);
    set_exp(39, -1);
    rx_check("len37", 37, 2, 1'b1);

    fill_pdu(0);
    send_pkt(6'd0, 2, -1, 1'b0, -1);
    set_exp(2, -1);
    rx_check("len0", 0, 2, 1'b1);

    fill_pdu(6);
    send_pkt(6'd39, 8, -1, 1'b0, -1);
    set_exp(8, -1);
    wait_valid();
    chk("hold_valid", pkt_valid, 1'b1);
    mon_cycles = 0;
    mon_bad    = 0;
    mon_on     = 1'b1;
    fill_pdu(6);
    send_pkt(6'd3, 8, -1, 1'b0, -1);
    while (mon_cycles < 100) tick();
    mon_on = 1'b0;
    chk("hold_stable_bad_cycles", mon_bad, 0);
    chk("hold_len", pkt_len, 6);
    accept(1'b1);
    repeat (4) tick();
    chk("hold_second_lost", pkt_valid, 1'b0);
    chk_counters("hold");

    fill_pdu(10);
    send_pkt(6'd8, 12, -1, 1'b0, 40 + 16 + 30);
    en = 1'b0;
    tick();
    en = 1'b1;
    repeat (40) send_bit(1'($urandom), 0);
    chk("abort_no_valid", pkt_valid, 1'b0);
    chk_counters("abort");
    fill_pdu(3);
    send_pkt(6'd9, 5, -1, 1'b0, -1);
    set_exp(5, -1);
    rx_check("after_abort", 3, 2, 1'b1);

    fill_pdu(4);
    send_pkt(6'd17, 6, -1, 1'b1, -1);
`ifdef BLE_RX_PREAMBLE_CHECK_EN
    repeat (4) tick();
    chk("pre_bad_no_valid", pkt_valid, 1'b0);
    send_pkt(6'd17, 6, -1, 1'b0, -1);
`endif
    set_exp(6, -1);
    rx_check("preamble", 4, 2, 1'b1);

    for (int n = 0; n < 16; n++) begin
      fs = $urandom_range(0, NA - 1);
      for (int s = 0; s < NA; s++) begin
        acc_addr[32*s +: 32] = ($urandom_range(0, 1) == 1) ? ADV_AA : 32'($urandom);
        addr_slot_en[s]      = 1'($urandom);
      end
      acc_addr[32*fs +: 32] = ADV_AA;
      addr_slot_en[fs]      = 1'b1;
      es = -1;
      for (int s = NA - 1; s >= 0; s--)
        if (addr_slot_en[s] && acc_addr[32*s +: 32] == ADV_AA) es = s;
      case (n % 4)
        0:       len = 0;
        1:       len = 37;
        default: len = $urandom_range(1, 37);
      endcase
      flip = (len > 0 && $urandom_range(0, 2) == 0) ? 16 + $urandom_range(0, 8 * len - 1) : -1;
      ch = 6'($urandom_range(0, 39));
      fill_pdu(len);
      send_pkt(ch, len + 2, flip, 1'b0, -1);
      set_exp(len + 2, flip);
      rx_check($sformatf("rand%0d", n), len, es, flip < 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    fill_pdu(5);
    send_pkt(6'd1, 7, -1, 1'b0, 40 + 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pkt = 0; exp_err = 0; exp_ovf = 0;
    repeat (40) send_bit(1'($urandom), 0);
    chk("midrst_valid", pkt_valid, 1'b0);
    chk("midrst_data", pkt_data, '0);
    chk_counters("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
